ftdi_sync245_arbiter: RTL and testbench



---
 rtl/ftdi_sync245_arbiter.sv | 120 ++++++++++++
 tb/tb_ftdi_sync245_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftdi_sync245_arbiter.sv
// ftdi_sync245_arbiter: FT2232H sync-245 FIFO bus master sharing ftdi_d between RX and TX bursts.
// Optional build macro FTDI_SIWUA_EN enables the SIWU# send-immediate pulse requested by tx_flush.
module ftdi_sync245_arbiter #(
  parameter int BURST_MAX = 64
) (
  input  logic       ftdi_clk,
  input  logic       sys_rst,
  input  logic [7:0] ftdi_d_i,
  output logic [7:0] ftdi_d_o,
  output logic       ftdi_d_oe,
  input  logic       ftdi_rxf_n,
  input  logic       ftdi_txe_n,
  output logic       ftdi_rd_n,
  output logic       ftdi_wr_n,
  output logic       ftdi_oe_n,
  output logic       ftdi_siwua_n,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_afull,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       tx_flush
);

  typedef enum logic [2:0] {IDLE, RX_OE, RX_RD, RX_END, TX_WR, TX_END} state_t;

  localparam logic [7:0] LAST = 8'(BURST_MAX - 1);

  state_t     state, state_nxt;
  logic [7:0] count;
  logic       last_dir_tx, last_dir_nxt;
  logic       rd_q, oe_q, wr_q, doe_q;
  logic       rx_pend, tx_pend, rx_capture, tx_accept;

  assign rx_pend = !ftdi_rxf_n && !rx_afull;
  assign tx_pend = !ftdi_txe_n && tx_valid;

  // wr_n is gated by tx_valid so the FTDI never latches a stale byte once the FIFO runs dry
  assign ftdi_wr_n  = wr_q || !tx_valid;
  assign rx_capture = !rd_q && !ftdi_rxf_n;
  assign tx_accept  = !ftdi_wr_n && !ftdi_txe_n;
  assign tx_ready   = tx_accept;
  assign ftdi_rd_n  = rd_q;
  assign ftdi_oe_n  = oe_q;
  assign ftdi_d_oe  = doe_q;
  assign ftdi_d_o   = tx_data;

`ifdef FTDI_SIWUA_EN
  logic flush_flag, siwua_fire;

  assign siwua_fire   = (state == IDLE) && flush_flag && !tx_valid;
  assign ftdi_siwua_n = !siwua_fire;

  always_ff @(posedge ftdi_clk) begin
    if (sys_rst) flush_flag <= 1'b0;
    else         flush_flag <= tx_flush || (flush_flag && !siwua_fire);
  end
`else
  logic unused_flush;

  assign unused_flush = tx_flush;
  assign ftdi_siwua_n = 1'b1;
`endif

  always_comb begin
    state_nxt    = state;
    last_dir_nxt = last_dir_tx;
    case (state)
      IDLE: begin
        if (rx_pend && (!tx_pend || last_dir_tx)) begin
          state_nxt    = RX_OE;
          last_dir_nxt = 1'b0;
        end else if (tx_pend) begin
          state_nxt    = TX_WR;
          last_dir_nxt = 1'b1;
        end
      end
      RX_OE:  state_nxt = RX_RD;
      RX_RD:  if (ftdi_rxf_n || rx_afull || (rx_capture && count == LAST)) state_nxt = RX_END;
      RX_END: state_nxt = IDLE;
      TX_WR:  if (ftdi_txe_n || !tx_valid || (tx_accept && count == LAST)) state_nxt = TX_END;
      TX_END: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so the pins are glitch-free decodes of the state
  always_ff @(posedge ftdi_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      last_dir_tx <= 1'b1;
      rd_q        <= 1'b1;
      oe_q        <= 1'b1;
      wr_q        <= 1'b1;
      doe_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_dir_tx <= last_dir_nxt;
      rd_q        <= !(state_nxt == RX_RD);
      oe_q        <= !(state_nxt == RX_OE || state_nxt == RX_RD);
      wr_q        <= !(state_nxt == TX_WR);
      doe_q       <= (state_nxt == TX_WR);
    end
  end

  always_ff @(posedge ftdi_clk) begin
    if (sys_rst) begin
      count    <= 8'd0;
      rx_valid <= 1'b0;
      rx_data  <= 8'd0;
    end else begin
      if (state_nxt != state && (state_nxt == RX_OE || state_nxt == TX_WR)) count <= 8'd0;
      else if (rx_capture || tx_accept) count <= count + 8'd1;
      rx_valid <= rx_capture;
      if (rx_capture) rx_data <= ftdi_d_i;
    end
  end

endmodule

// File: tb/tb_ftdi_sync245_arbiter.sv
// tb_ftdi_sync245_arbiter: models the FTDI chip and the TX FIFO around the arbiter and
// scoreboards every byte that crosses in either direction.
module tb_ftdi_sync245_arbiter;

  localparam int BURST = 4;

  logic       ftdi_clk;
  logic       sys_rst;
  logic [7:0] ftdi_d_i, ftdi_d_o, rx_data, tx_data;
  logic       ftdi_d_oe, ftdi_rxf_n, ftdi_txe_n, ftdi_rd_n, ftdi_wr_n, ftdi_oe_n, ftdi_siwua_n;
  logic       rx_valid, rx_afull, tx_valid, tx_ready, tx_flush;

  ftdi_sync245_arbiter #(.BURST_MAX(BURST)) dut (
    .ftdi_clk(ftdi_clk), .sys_rst(sys_rst),
    .ftdi_d_i(ftdi_d_i), .ftdi_d_o(ftdi_d_o), .ftdi_d_oe(ftdi_d_oe),
    .ftdi_rxf_n(ftdi_rxf_n), .ftdi_txe_n(ftdi_txe_n),
    .ftdi_rd_n(ftdi_rd_n), .ftdi_wr_n(ftdi_wr_n), .ftdi_oe_n(ftdi_oe_n),
    .ftdi_siwua_n(ftdi_siwua_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_afull(rx_afull),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_flush(tx_flush)
  );

  initial ftdi_clk = 1'b0;
  always #5 ftdi_clk = ~ftdi_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_src[$], rx_exp[$], tx_fifo[$], tx_exp[$];
  int         bursts[$];
  int         cur_dir = 0, cur_len = 0;
  int         rx_pops = 0, tx_writes = 0, rx_seen = 0, siwua_lows = 0;
  logic       pop_rx, pop_tx;
  logic       obs_rd_n, obs_oe_n, obs_tx_ready;

  task automatic drive_model();
    ftdi_rxf_n = (rx_src.size() == 0);
    ftdi_d_i   = (rx_src.size() != 0) ? rx_src[0] : 8'h00;
    tx_valid   = (tx_fifo.size() != 0);
    tx_data    = (tx_fifo.size() != 0) ? tx_fifo[0] : 8'h00;
  endtask

  task automatic load_rx(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      rx_src.push_back(first + 8'(i));
      rx_exp.push_back(first + 8'(i));
    end
    drive_model();
  endtask

  task automatic load_tx(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      tx_fifo.push_back(first + 8'(i));
      tx_exp.push_back(first + 8'(i));
    end
    drive_model();
  endtask

  // Bursts are runs of consecutive transfer cycles in one direction, encoded dir*256+len
  task automatic note_dir(input int dir);
    if (dir != cur_dir) begin
      if (cur_len > 0) bursts.push_back(cur_dir * 256 + cur_len);
      cur_dir = dir;
      cur_len = 0;
    end
    if (dir != 0) cur_len++;
  endtask

  task automatic cycle();
    logic       wr_accept;
    logic [7:0] exp_b;
    @(negedge ftdi_clk);
    obs_rd_n     = ftdi_rd_n;
    obs_oe_n     = ftdi_oe_n;
    obs_tx_ready = tx_ready;
    wr_accept    = !ftdi_wr_n && !ftdi_txe_n;
    checks++;
    if ((ftdi_d_oe && !ftdi_oe_n) || (!ftdi_rd_n && !ftdi_wr_n) || (tx_ready !== wr_accept)) begin
      errors++;
      $display("[TB] FAIL bus_protocol: d_oe=%b oe_n=%b rd_n=%b wr_n=%b tx_ready=%b, required no overlap and tx_ready=%b",
               ftdi_d_oe, ftdi_oe_n, ftdi_rd_n, ftdi_wr_n, tx_ready, wr_accept);
    end
    if (rx_valid) begin
      rx_seen++;
      checks++;
      if (rx_exp.size() == 0) begin
        errors++;
        $display("[TB] FAIL rx_unexpected: got rx_data=%h, required no byte", rx_data);
      end else begin
        exp_b = rx_exp.pop_front();
        if (rx_data !== exp_b) begin
          errors++;
          $display("[TB] FAIL rx_data: got %h, required %h", rx_data, exp_b);
        end
      end
    end
    if (wr_accept) begin
      tx_writes++;
      checks++;
      if (tx_exp.size() == 0) begin
        errors++;
        $display("[TB] FAIL tx_unexpected: got ftdi_d_o=%h, required no write", ftdi_d_o);
      end else begin
        exp_b = tx_exp.pop_front();
        if (ftdi_d_o !== exp_b || ftdi_d_oe !== 1'b1) begin
          errors++;
          $display("[TB] FAIL tx_data: got %h (d_oe=%b), required %h (d_oe=1)", ftdi_d_o, ftdi_d_oe, exp_b);
        end
      end
    end
    if (!ftdi_siwua_n) siwua_lows++;
    note_dir(rx_valid ? 1 : (wr_accept ? 2 : 0));
    pop_rx = !ftdi_rd_n && !ftdi_rxf_n;
    pop_tx = tx_ready;
    @(posedge ftdi_clk);
    #1;
    if (pop_rx) begin
      void'(rx_src.pop_front());
      rx_pops++;
    end
    if (pop_tx) void'(tx_fifo.pop_front());
    drive_model();
  endtask

  task automatic test_reset();
    sys_rst    = 1'b1;
    rx_afull   = 1'b0;
    tx_flush   = 1'b0;
    ftdi_txe_n = 1'b1;
    drive_model();
    repeat (3) cycle();
    #1;
    checks++;
    if ({ftdi_rd_n, ftdi_wr_n, ftdi_oe_n, ftdi_siwua_n, ftdi_d_oe, rx_valid, tx_ready} !== 7'b1111000) begin
      errors++;
      $display("[TB] FAIL reset_strobes: got rd/wr/oe/siwu/doe/rxv/txr=%b, required 1111000",
               {ftdi_rd_n, ftdi_wr_n, ftdi_oe_n, ftdi_siwua_n, ftdi_d_oe, rx_valid, tx_ready});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_rx_data: got %h, required 00", rx_data);
    end
    sys_rst = 1'b0;
    repeat (3) cycle();
    checks++;
    if (obs_rd_n !== 1'b1 || obs_oe_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_no_pending: got rd_n=%b oe_n=%b, required 1 1", obs_rd_n, obs_oe_n);
    end
  endtask

  task automatic test_rx_single();
    int t_oe = -1, t_rd = -1, t_pop = -1, t_idle = -1;
    load_rx(8'h55, 1);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (!obs_oe_n && t_oe < 0) t_oe = i;
      if (!obs_rd_n && t_rd < 0) t_rd = i;
      if (pop_rx && t_pop < 0) t_pop = i;
      if (t_pop >= 0 && i > t_pop && obs_oe_n && obs_rd_n && t_idle < 0) t_idle = i;
    end
    checks++;
    if (t_oe < 0 || t_rd != t_oe + 1) begin
      errors++;
      $display("[TB] FAIL rx_single_oe_to_rd: got oe at %0d rd at %0d, required rd one cycle after oe", t_oe, t_rd);
    end
    checks++;
    if (t_pop < 0 || t_idle < 0 || t_idle - t_pop > 2) begin
      errors++;
      $display("[TB] FAIL rx_single_release: got pop at %0d release at %0d, required release within 2", t_pop, t_idle);
    end
    checks++;
    if (rx_exp.size() != 0) begin
      errors++;
      $display("[TB] FAIL rx_single_delivered: got %0d bytes outstanding, required 0", rx_exp.size());
    end
  endtask

  task automatic test_rx_burst_limit();
    int b;
    bursts.delete();
    load_rx(8'h01, 6);
    for (int i = 0; i < 60 && rx_exp.size() != 0; i++) cycle();
    repeat (5) cycle();
    checks++;
    if (rx_exp.size() != 0 || bursts.size() != 2) begin
      errors++;
      $display("[TB] FAIL rx_burst_count: got %0d bursts, %0d outstanding, required 2 bursts, 0 outstanding",
               bursts.size(), rx_exp.size());
    end
    for (int k = 0; k < 2 && bursts.size() != 0; k++) begin
      b = bursts.pop_front();
      checks++;
      if (b != 256 + ((k == 0) ? BURST : 6 - BURST)) begin
        errors++;
        $display("[TB] FAIL rx_burst_len%0d: got code %0d, required %0d", k, b, 256 + ((k == 0) ? BURST : 6 - BURST));
      end
    end
  endtask

  task automatic test_rx_backpressure();
    int pops0 = rx_pops, seen0 = rx_seen;
    load_rx(8'hA0, 6);
    for (int i = 0; i < 20 && rx_pops - pops0 < 2; i++) cycle();
    rx_afull = 1'b1;
    cycle();
    cycle();
    checks++;
    if (obs_rd_n !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rx_afull_rd_n: got rd_n=%b after afull edge, required 1", obs_rd_n);
    end
    repeat (8) cycle();
    checks++;
    if (rx_pops - pops0 != 3 || rx_seen - seen0 != 3) begin
      errors++;
      $display("[TB] FAIL rx_afull_bytes: got %0d read %0d delivered, required 3 3", rx_pops - pops0, rx_seen - seen0);
    end
    rx_afull = 1'b0;
    for (int i = 0; i < 40 && rx_exp.size() != 0; i++) cycle();
    repeat (4) cycle();
    checks++;
    if (rx_exp.size() != 0) begin
      errors++;
      $display("[TB] FAIL rx_afull_drain: got %0d outstanding, required 0", rx_exp.size());
    end
  endtask

  task automatic test_tx_stall();
    int w0 = tx_writes;
    ftdi_txe_n = 1'b0;
    tx_fifo.push_back(8'h11); tx_exp.push_back(8'h11);
    tx_fifo.push_back(8'hA5); tx_exp.push_back(8'hA5);
    load_tx(8'h22, 2);
    for (int i = 0; i < 20 && tx_writes - w0 < 1; i++) cycle();
    ftdi_txe_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++;
      if (obs_tx_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL tx_stall_ready%0d: got tx_ready=%b, required 0", k, obs_tx_ready);
      end
    end
    ftdi_txe_n = 1'b0;
    for (int i = 0; i < 30 && tx_exp.size() != 0; i++) cycle();
    repeat (4) cycle();
    checks++;
    if (tx_writes - w0 != 4 || tx_exp.size() != 0 || tx_fifo.size() != 0) begin
      errors++;
      $display("[TB] FAIL tx_stall_count: got %0d writes, %0d left in fifo, required 4 writes, 0 left",
               tx_writes - w0, tx_fifo.size());
    end
  endtask

  task automatic test_reset_mid_rx();
    int seen0;
    load_rx(8'hE0, 8);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (!obs_rd_n) break;
    end
    checks++;
    if (obs_rd_n !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_rx_reach: got rd_n=%b, required 0 before reset", obs_rd_n);
    end
    sys_rst = 1'b1;
    cycle();
    #1;
    checks++;
    if ({ftdi_rd_n, ftdi_wr_n, ftdi_oe_n, ftdi_d_oe, rx_valid} !== 5'b11100) begin
      errors++;
      $display("[TB] FAIL reset_mid_rx_strobes: got rd/wr/oe/doe/rxv=%b, required 11100",
               {ftdi_rd_n, ftdi_wr_n, ftdi_oe_n, ftdi_d_oe, rx_valid});
    end
    rx_src.delete();
    rx_exp.delete();
    drive_model();
    cycle();
    sys_rst = 1'b0;
    seen0 = rx_seen;
    repeat (6) cycle();
    checks++;
    if (rx_seen != seen0) begin
      errors++;
      $display("[TB] FAIL reset_mid_rx_drop: got %0d bytes after reset, required 0", rx_seen - seen0);
    end
  endtask

  task automatic test_alternation();
    int b, want;
    bursts.delete();
    load_rx(8'hC0, 3 * BURST);
    load_tx(8'hD0, 3 * BURST);
    for (int i = 0; i < 300 && (rx_exp.size() != 0 || tx_exp.size() != 0); i++) cycle();
    repeat (5) cycle();
    checks++;
    if (bursts.size() != 6) begin
      errors++;
      $display("[TB] FAIL alt_burst_count: got %0d bursts, required 6", bursts.size());
    end
    for (int k = 0; k < 6 && bursts.size() != 0; k++) begin
      b = bursts.pop_front();
      want = ((k % 2 == 0) ? 256 : 512) + BURST;
      checks++;
      if (b != want) begin
        errors++;
        $display("[TB] FAIL alt_burst%0d: got code %0d, required %0d", k, b, want);
      end
    end
  endtask

  task automatic test_siwua();
    int lows0 = siwua_lows;
    int want;
`ifdef FTDI_SIWUA_EN
    want = 1;
`else
    want = 0;
`endif
    tx_flush = 1'b1;
    cycle();
    tx_flush = 1'b0;
    repeat (6) cycle();
    checks++;
    if (siwua_lows - lows0 != want) begin
      errors++;
      $display("[TB] FAIL siwua_pulse: got %0d low cycles, required %0d", siwua_lows - lows0, want);
    end
  endtask

  initial begin
    test_reset();
    test_rx_single();
    test_rx_burst_limit();
    test_rx_backpressure();
    test_tx_stall();
    test_reset_mid_rx();
    test_alternation();
    test_siwua();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
